// File: rtl/vh_pkg.sv
// Shared definitions for the stimulus/signature stage.
// Holds the FSM state encoding, MISR constants, the Galois LFSR tap table
// and the word-folding helper used by the MISR.
package vh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] MISR_POLY  = 32'h04C11DB7;
  localparam logic [31:0] MISR_INIT  = 32'hFFFFFFFF;

  // Widest DUT output the fold helper accepts (8 chunks of 32 bits).
  localparam int unsigned FOLD_MAX_W = 256;

  // Maximal-length tap masks for a right-shift Galois LFSR, indexed by
  // register width 2..32. Bit i set means "XOR into bit i after the shift".
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] t;
    case (w)
      2:  t = 32'h00000003;
      3:  t = 32'h00000006;
      4:  t = 32'h0000000C;
      5:  t = 32'h00000014;
      6:  t = 32'h00000030;
      7:  t = 32'h00000060;
      8:  t = 32'h000000B8;
      9:  t = 32'h00000110;
      10: t = 32'h00000240;
      11: t = 32'h00000500;
      12: t = 32'h00000829;
      13: t = 32'h0000100D;
      14: t = 32'h00002015;
      15: t = 32'h00006000;
      16: t = 32'h0000D008;
      17: t = 32'h00012000;
      18: t = 32'h00020400;
      19: t = 32'h00040023;
      20: t = 32'h00090000;
      21: t = 32'h00140000;
      22: t = 32'h00300000;
      23: t = 32'h00420000;
      24: t = 32'h00E10000;
      25: t = 32'h01200000;
      26: t = 32'h02000023;
      27: t = 32'h04000013;
      28: t = 32'h09000000;
      29: t = 32'h14000000;
      30: t = 32'h20000029;
      31: t = 32'h48000000;
      32: t = 32'h80200003;
      default: t = 32'h00000000;
    endcase
    return t;
  endfunction

  // XOR together the 32-bit chunks of a zero-extended output word.
  // Only the chunks covering y_w bits are visited; the rest are zero anyway.
  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] y,
                                         input int unsigned          y_w);
    logic [31:0] f;
    f = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W / 32; i++) begin
      if (i < (y_w + 32'd31) / 32'd32) begin
        f = f ^ y[i*32 +: 32];
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/vh_misr32.sv
// Purpose : 32-bit folding MISR; compresses one Y_W-bit word per enabled edge.
// Latency : din folded into sig at the edge where en=1; clr loads the init value.
// Backpr. : none; the caller qualifies every word with en.
// Ports   : clk, rst (async, active-high -> sig=0), clr (load MISR_INIT, wins
//           over en), en (fold din), din[Y_W], sig[32] (current MISR state).
module vh_misr32
  import vh_pkg::*;
#(
  parameter int Y_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [Y_W-1:0] din,
  output logic [31:0]    sig
);

  logic [FOLD_MAX_W-1:0] w_din_ext;
  logic [31:0]           w_fold;
  logic [31:0]           w_next;
  logic [31:0]           r_sig;

  always_comb begin
    w_din_ext          = '0;
    w_din_ext[Y_W-1:0] = din;
  end

  assign w_fold = fold32(w_din_ext, Y_W);

  // Shift first, reduce by the polynomial on carry-out, then inject the word.
  assign w_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_fold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= MISR_INIT;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/vh_stim_sig.sv
// Purpose : drive N_VEC vectors (counter or Galois LFSR) into a combinational
//           DUT and fold each response into a 32-bit MISR signature.
// Latency : start-to-done N_VEC+2 cycles (one capture stage plus one flush).
// Backpr. : none; start is only honoured in IDLE/DONE, ignored while busy.
// Ports   : clk, rst (async, active-high), start, dut_a[A_W] (vector out),
//           dut_y[Y_W] (DUT response in), busy, done, signature[32], vec_cnt[32].
module vh_stim_sig
  import vh_pkg::*;
#(
  parameter int          A_W   = 8,
  parameter int          Y_W   = 16,
  parameter logic [31:0] N_VEC = 32'd256,
  parameter int          MODE  = 0,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [A_W-1:0] dut_a,
  input  logic [Y_W-1:0] dut_y,
  output logic           busy,
  output logic           done,
  output logic [31:0]    signature,
  output logic [31:0]    vec_cnt
);

  localparam logic [31:0]    LAST_IDX = N_VEC - 32'd1;
  localparam logic [31:0]    TAP_FULL = lfsr_taps(A_W);
  localparam logic [A_W-1:0] TAP_A    = TAP_FULL[A_W-1:0];
  localparam logic [A_W-1:0] A_ONE    = {{(A_W-1){1'b0}}, 1'b1};
  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [A_W-1:0] SEED_A   = (SEED[A_W-1:0] == '0) ? A_ONE : SEED[A_W-1:0];
  localparam logic [A_W-1:0] A_INIT   = (MODE == 1) ? SEED_A : '0;

  state_t         r_state;
  logic [A_W-1:0] r_a;
  logic [31:0]    r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [Y_W-1:0] r_y_q;
  logic           r_y_v;

  logic [A_W-1:0] w_a_next;
  logic           w_start_ok;
  logic [31:0]    w_sig;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Counter mode keeps dut_a equal to vec_cnt modulo 2^A_W.
  always_comb begin
    if (MODE == 1) begin
      w_a_next = r_a[0] ? ((r_a >> 1) ^ TAP_A) : (r_a >> 1);
    end else begin
      w_a_next = r_a + A_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_a     <= A_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_a   <= w_a_next;
          r_cnt <= r_cnt + 32'd1;
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The last captured response is folded at this edge.
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Capture stage: every cycle spent in RUN drives exactly one valid vector,
  // so the response is registered and folded one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q <= '0;
      r_y_v <= 1'b0;
    end else begin
      r_y_v <= (r_state == ST_RUN);
      if (r_state == ST_RUN) begin
        r_y_q <= dut_y;
      end
    end
  end

  vh_misr32 #(
    .Y_W (Y_W)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (r_y_v),
    .din (r_y_q),
    .sig (w_sig)
  );

  assign dut_a     = r_a;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = w_sig;
  assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_vh_stim_sig.sv
module tb_vh_stim_sig;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  st;
  logic [15:0] key;

  // 0: exhaustive identity, A_W=2, N_VEC=4
  logic [1:0]  id_a, id_y;
  logic        id_busy, id_done;
  logic [31:0] id_sig, id_cnt;
  assign id_y = id_a;
  vh_stim_sig #(.A_W(2), .Y_W(2), .N_VEC(32'd4), .MODE(0), .SEED(32'd1)) u_id (
    .clk(clk), .rst(rst), .start(st[0]), .dut_a(id_a), .dut_y(id_y),
    .busy(id_busy), .done(id_done), .signature(id_sig), .vec_cnt(id_cnt));

  // 1: LFSR period, A_W=4, SEED=1, N_VEC=16 (one past the period)
  logic [3:0]  lf_a, lf_y;
  logic        lf_busy, lf_done;
  logic [31:0] lf_sig, lf_cnt;
  assign lf_y = lf_a;
  vh_stim_sig #(.A_W(4), .Y_W(4), .N_VEC(32'd16), .MODE(1), .SEED(32'd1)) u_lf (
    .clk(clk), .rst(rst), .start(st[1]), .dut_a(lf_a), .dut_y(lf_y),
    .busy(lf_busy), .done(lf_done), .signature(lf_sig), .vec_cnt(lf_cnt));

  // 2: wide fold, Y_W=64, N_VEC=1, LFSR with zero seed (must start at 1)
  logic [1:0]  wd_a;
  logic [63:0] wd_y;
  logic        wd_busy, wd_done;
  logic [31:0] wd_sig, wd_cnt;
  assign wd_y = 64'h0000_0001_0000_0001;
  vh_stim_sig #(.A_W(2), .Y_W(64), .N_VEC(32'd1), .MODE(1), .SEED(32'd0)) u_wd (
    .clk(clk), .rst(rst), .start(st[2]), .dut_a(wd_a), .dut_y(wd_y),
    .busy(wd_busy), .done(wd_done), .signature(wd_sig), .vec_cnt(wd_cnt));

  // 3: randomised runs, A_W=8, N_VEC=8, keyed expression under test
  logic [7:0]  rn_a;
  logic [15:0] rn_y;
  logic        rn_busy, rn_done;
  logic [31:0] rn_sig, rn_cnt;
  assign rn_y = {rn_a ^ key[7:0], rn_a + key[15:8]};
  vh_stim_sig #(.A_W(8), .Y_W(16), .N_VEC(32'd8), .MODE(1), .SEED(32'h5A)) u_rn (
    .clk(clk), .rst(rst), .start(st[3]), .dut_a(rn_a), .dut_y(rn_y),
    .busy(rn_busy), .done(rn_done), .signature(rn_sig), .vec_cnt(rn_cnt));

  // Per-instance description used by the reference model. Instance 2 is
  // built with SEED=0, so its effective first vector is 1.
  int          inst_aw   [4] = '{2, 4, 2, 8};
  int          inst_n    [4] = '{4, 16, 1, 8};
  int          inst_mode [4] = '{0, 1, 1, 1};
  logic [31:0] inst_seed [4] = '{32'd1, 32'd1, 32'd1, 32'h5A};
  logic [31:0] inst_tap  [4] = '{32'h0, 32'hC, 32'h3, 32'hB8};

  int          sel;
  logic [31:0] o_a, o_sig, o_cnt;
  logic        o_busy, o_done;

  always_comb begin
    o_a = '0; o_sig = '0; o_cnt = '0; o_busy = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin o_a = 32'(id_a); o_sig = id_sig; o_cnt = id_cnt; o_busy = id_busy; o_done = id_done; end
      1: begin o_a = 32'(lf_a); o_sig = lf_sig; o_cnt = lf_cnt; o_busy = lf_busy; o_done = lf_done; end
      2: begin o_a = 32'(wd_a); o_sig = wd_sig; o_cnt = wd_cnt; o_busy = wd_busy; o_done = wd_done; end
      default: begin o_a = 32'(rn_a); o_sig = rn_sig; o_cnt = rn_cnt; o_busy = rn_busy; o_done = rn_done; end
    endcase
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] obs_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector k of a run, straight from the sequence definition.
  function automatic logic [31:0] ref_vec(input int idx, input int k);
    logic [31:0] a;
    if (inst_mode[idx] == 0) begin
      return 32'(k % (1 << inst_aw[idx]));
    end
    a = inst_seed[idx];
    for (int i = 0; i < k; i++) begin
      if (a[0]) a = (a >> 1) ^ inst_tap[idx];
      else      a = a >> 1;
    end
    return a;
  endfunction

  function automatic logic [63:0] ref_y(input int idx, input logic [31:0] a);
    logic [7:0] hi, lo;
    case (idx)
      2: return 64'h0000_0001_0000_0001;
      3: begin
        hi = a[7:0] ^ key[7:0];
        lo = a[7:0] + key[15:8];
        return {48'h0, hi, lo};
      end
      default: return {32'h0, a};
    endcase
  endfunction

  function automatic logic [31:0] ref_sig(input int idx);
    logic [31:0] s, f;
    logic [63:0] y;
    s = 32'hFFFFFFFF;
    for (int k = 0; k < inst_n[idx]; k++) begin
      y = ref_y(idx, ref_vec(idx, k));
      f = y[31:0] ^ y[63:32];
      s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    end
    return s;
  endfunction

  // Called just after a falling edge; that cycle is cycle 0 of the run.
  // hold keeps start high throughout; pulse_c raises start for one cycle;
  // rst_c fires an asynchronous reset between edges in that cycle.
  task automatic run(input int idx, input bit hold, input int pulse_c,
                     input int rst_c, output bit aborted);
    logic [31:0] exp_sig;
    int n;
    sel     = idx;
    aborted = 1'b0;
    n       = inst_n[idx];
    exp_sig = ref_sig(idx);
    obs_q.delete();
    st[idx] = 1'b1;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (!hold) st[idx] = (c == pulse_c);
      if (c <= n) begin
        obs_q.push_back(o_a);
        chk($sformatf("dut_a[%0d] inst%0d", c - 1, idx), o_a, ref_vec(idx, c - 1));
        chk($sformatf("vec_cnt c%0d inst%0d", c, idx), o_cnt, 64'(c - 1));
        chk("busy in RUN", o_busy, 1);
        chk("done in RUN", o_done, 0);
      end else if (c == n + 1) begin
        chk("busy in FLUSH", o_busy, 1);
        chk("done in FLUSH", o_done, 0);
      end else begin
        chk("busy in DONE", o_busy, 0);
        chk($sformatf("done at cycle %0d inst%0d", c, idx), o_done, 1);
        chk($sformatf("signature inst%0d", idx), o_sig, exp_sig);
      end
      if (c == rst_c) begin
        #1 rst = 1'b1;
        #1;
        chk("rst dut_a", o_a, 0);
        chk("rst busy", o_busy, 0);
        chk("rst done", o_done, 0);
        chk("rst signature", o_sig, 0);
        chk("rst vec_cnt", o_cnt, 0);
        #1 rst = 1'b0;
        st[idx] = 1'b0;
        aborted = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit         ab;
    logic [15:0] seen;
    int          choice;

    rst = 1'b1;
    st  = '0;
    key = 16'h1234;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      chk($sformatf("reset dut_a inst%0d", i), o_a, 0);
      chk("reset busy", o_busy, 0);
      chk("reset done", o_done, 0);
      chk("reset signature", o_sig, 0);
      chk("reset vec_cnt", o_cnt, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Exhaustive identity run with a known golden signature.
    run(0, 1'b0, -1, -1, ab);
    chk("identity golden", o_sig, 32'hC7B0424E);

    // LFSR: first 15 vectors distinct and nonzero, vector 15 wraps to SEED.
    @(negedge clk);
    run(1, 1'b0, -1, -1, ab);
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      chk("lfsr nonzero", 64'(obs_q[k] != 0), 1);
      chk("lfsr unique", 64'(seen[obs_q[k][3:0]]), 0);
      seen[obs_q[k][3:0]] = 1'b1;
    end
    chk("lfsr vector15", obs_q[15], 1);

    // Wide fold: chunks cancel, signature is init shifted once plus poly.
    @(negedge clk);
    run(2, 1'b0, -1, -1, ab);
    chk("wide fold golden", o_sig, 32'hFB3EE249);

    // Clean run, start pulse in cycle 3, reset in cycle 4 plus restart.
    @(negedge clk);
    run(3, 1'b0, -1, -1, ab);
    @(negedge clk);
    run(3, 1'b0, 3, -1, ab);
    @(negedge clk);
    run(3, 1'b0, -1, 4, ab);
    chk("reset aborted run", 64'(ab), 1);
    run(3, 1'b0, -1, -1, ab);

    // Back-to-back with start held high across DONE.
    @(negedge clk);
    run(3, 1'b1, -1, -1, ab);
    run(3, 1'b1, -1, -1, ab);
    st[3] = 1'b0;

    // Randomised keys, gaps, start pulses and resets.
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      key = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      choice = $urandom_range(0, 2);
      if (choice == 0) begin
        run(3, 1'b0, -1, -1, ab);
      end else if (choice == 1) begin
        run(3, 1'b0, $urandom_range(1, 9), -1, ab);
      end else begin
        run(3, 1'b0, -1, $urandom_range(1, 10), ab);
        run(3, 1'b0, -1, -1, ab);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
